// File: rtl/arb_sequence_controller.sv
// Arbitrary-sequence playback controller: replays table entries 0..seq_len with repeat, step and stop control.
// Define ARBSEQ_PROG_EN to make the code table writable through wr_en/wr_addr/wr_data while idle.
module arb_sequence_controller #(
  parameter int unsigned WIDTH = 3,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned REP_W = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       start,
  input  logic                       stop,
  input  logic                       step_mode,
  input  logic                       step,
  input  logic [$clog2(DEPTH)-1:0]   seq_len,
  input  logic [REP_W-1:0]           repeat_cnt,
  input  logic                       wr_en,
  input  logic [$clog2(DEPTH)-1:0]   wr_addr,
  input  logic [WIDTH-1:0]           wr_data,
  output logic [WIDTH-1:0]           OUTPUT,
  output logic                       valid,
  output logic                       busy,
  output logic                       wrap,
  output logic                       done
);

  localparam int unsigned IDX_W = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [IDX_W-1:0]   len_q, len_d;
  logic [REP_W-1:0]   passes_q, passes_d;
  logic [WIDTH-1:0]   out_q, out_d;
  logic               valid_q, valid_d;
  logic               busy_q, busy_d;
  logic               wrap_q, wrap_d;
  logic               done_q, done_d;
  logic               advance;
  logic [WIDTH-1:0]   rd_code;
  logic [WIDTH-1:0]   tbl [DEPTH];

  // Power-on contents: the standard 0,1,2,3,6,5,7 pattern, zero beyond.
  function automatic logic [WIDTH-1:0] default_code(input int unsigned i);
    logic [WIDTH-1:0] c;
    case (i)
      1:       c = WIDTH'(1);
      2:       c = WIDTH'(2);
      3:       c = WIDTH'(3);
      4:       c = WIDTH'(6);
      5:       c = WIDTH'(5);
      6:       c = WIDTH'(7);
      default: c = '0;
    endcase
    return c;
  endfunction

`ifdef ARBSEQ_PROG_EN
  logic wr_fire;
  assign wr_fire = wr_en && (state_q == IDLE);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) tbl[i] <= default_code(i);
    end else if (wr_fire) begin
      tbl[wr_addr] <= wr_data;
    end
  end
`else
  logic unused_wr;
  assign unused_wr = ^{wr_en, wr_addr, wr_data};

  always_comb begin
    for (int unsigned i = 0; i < DEPTH; i++) tbl[i] = default_code(i);
  end
`endif

  assign advance = step_mode ? step : 1'b1;

  // Next-state and next-output logic; outputs are registered from the _d values.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    len_d    = len_q;
    passes_d = passes_q;
    wrap_d   = 1'b0;
    done_d   = 1'b0;
    rd_code  = '0;

    unique case (state_q)
      IDLE: begin
        if (start && !stop) begin
          state_d  = RUN;
          idx_d    = '0;
          len_d    = seq_len;
          passes_d = repeat_cnt;
        end
      end
      RUN: begin
        if (stop) begin
          state_d = IDLE;
          idx_d   = '0;
        end else if (advance) begin
          if (idx_q != len_q) begin
            idx_d = idx_q + IDX_W'(1);
          end else if (passes_q != REP_W'(1)) begin
            idx_d  = '0;
            wrap_d = 1'b1;
            if (passes_q != '0) passes_d = passes_q - REP_W'(1);
          end else begin
            state_d = FINISH;
            idx_d   = '0;
            done_d  = 1'b1;
          end
        end
      end
      FINISH: begin
        state_d = IDLE;
        idx_d   = '0;
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
      end
    endcase

    rd_code = tbl[idx_d];
`ifdef ARBSEQ_PROG_EN
    // A write coincident with start must be visible in the first code.
    if (wr_fire && (wr_addr == idx_d)) rd_code = wr_data;
`endif

    valid_d = (state_d == RUN);
    busy_d  = (state_d != IDLE);
    out_d   = (state_d == RUN) ? rd_code : '0;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      len_q    <= '0;
      passes_q <= '0;
      out_q    <= '0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      wrap_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      len_q    <= len_d;
      passes_q <= passes_d;
      out_q    <= out_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
      wrap_q   <= wrap_d;
      done_q   <= done_d;
    end
  end

  assign OUTPUT = out_q;
  assign valid  = valid_q;
  assign busy   = busy_q;
  assign wrap   = wrap_q;
  assign done   = done_q;

endmodule

// File: tb/tb_arb_sequence_controller.sv
// Bench for arb_sequence_controller: vector table, directed corner sequences and a random run
// checked every cycle against a pass/position reference model.
module tb_arb_sequence_controller;

  localparam int unsigned WIDTH = 3;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned REP_W = 4;
  localparam int unsigned IDX_W = 3;
`ifdef ARBSEQ_PROG_EN
  localparam bit PROG = 1'b1;
`else
  localparam bit PROG = 1'b0;
`endif

  logic             clock = 1'b0;
  logic             reset;
  logic             start, stop, step_mode, step, wr_en;
  logic [IDX_W-1:0] seq_len, wr_addr;
  logic [REP_W-1:0] repeat_cnt;
  logic [WIDTH-1:0] wr_data;
  logic [WIDTH-1:0] OUTPUT;
  logic             valid, busy, wrap, done;

  always #5 clock = ~clock;

  arb_sequence_controller #(.WIDTH(WIDTH), .DEPTH(DEPTH), .REP_W(REP_W)) dut (
    .clock(clock), .reset(reset), .start(start), .stop(stop),
    .step_mode(step_mode), .step(step), .seq_len(seq_len), .repeat_cnt(repeat_cnt),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .OUTPUT(OUTPUT), .valid(valid), .busy(busy), .wrap(wrap), .done(done)
  );

  int vectors = 0;
  int miscompares = 0;
  int codes [8] = '{0, 1, 2, 3, 6, 5, 7, 0};

  // Reference model: playing/position/codes-left view of playback.
  bit               m_play, m_fin, m_wrap;
  int               m_pos, m_len, m_left;
  logic [WIDTH-1:0] m_tbl [DEPTH];
  logic [WIDTH-1:0] got [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endtask

  task automatic m_reset();
    m_play = 0; m_fin = 0; m_wrap = 0; m_pos = 0; m_len = 1; m_left = 0;
    for (int i = 0; i < DEPTH; i++) m_tbl[i] = WIDTH'(codes[i]);
  endtask

  task automatic m_step();
    bit nw, nf;
    nw = 0; nf = 0;
    if (m_fin) begin
      // finish cycle always returns to idle
    end else if (m_play) begin
      if (stop) m_play = 0;
      else if (!step_mode || step) begin
        if (m_left == 1) begin
          m_play = 0; nf = 1;
        end else begin
          m_pos = (m_pos + 1) % m_len;
          if (m_left > 0) m_left--;
          nw = (m_pos == 0);
        end
      end
    end else begin
      if (PROG && wr_en) m_tbl[wr_addr] = wr_data;
      if (start && !stop) begin
        m_play = 1; m_pos = 0; m_len = int'(seq_len) + 1;
        m_left = (repeat_cnt == 0) ? -1 : int'(repeat_cnt) * m_len;
      end
    end
    m_fin = nf; m_wrap = nw;
    if (!m_play) m_pos = 0;
  endtask

  task automatic tick();
    logic [WIDTH-1:0] eo;
    @(posedge clock);
    m_step();
    #1;
    eo = m_play ? m_tbl[m_pos] : {WIDTH{1'b0}};
    chk("cycle_model", 32'({OUTPUT, valid, busy, wrap, done}),
        32'({eo, m_play, (m_play | m_fin), m_wrap, m_fin}));
  endtask

  task automatic quiet();
    start = 0; stop = 0; step = 0; wr_en = 0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (busy && n < 60) begin tick(); n++; end
    chk("drain_idle", 32'(busy), 32'd0);
  endtask

  // Start a free-running pass and capture the first n codes.
  task automatic start_run(input int len, input int rep, input int n);
    seq_len = IDX_W'(len); repeat_cnt = REP_W'(rep); step_mode = 0; start = 1;
    tick();
    start = 0; wr_en = 0;
    got[0] = OUTPUT;
    for (int i = 1; i < n; i++) begin tick(); got[i] = OUTPUT; end
  endtask

  typedef struct {
    logic             start;
    logic [IDX_W-1:0] len;
    logic [REP_W-1:0] rep;
    logic [WIDTH-1:0] out;
    logic             valid, busy, wrap, done;
  } vec_t;
  vec_t vt [9];

  initial begin
    int nv, nw, nd, wat, n;
    logic [WIDTH-1:0] e4 [4];

    reset = 0; quiet(); step_mode = 0; seq_len = '0; repeat_cnt = '0;
    wr_addr = '0; wr_data = '0;
    m_reset();
    #1;
    chk("reset_state", 32'({OUTPUT, valid, busy, wrap, done}), 32'd0);
    @(posedge clock); #1 reset = 1;

    // Single pass, table-driven
    for (int i = 0; i < 7; i++)
      vt[i] = '{(i == 0), IDX_W'(6), REP_W'(1), WIDTH'(codes[i]), 1'b1, 1'b1, 1'b0, 1'b0};
    vt[7] = '{1'b0, IDX_W'(6), REP_W'(1), '0, 1'b0, 1'b1, 1'b0, 1'b1};
    vt[8] = '{1'b0, IDX_W'(6), REP_W'(1), '0, 1'b0, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 9; i++) begin
      start = vt[i].start; seq_len = vt[i].len; repeat_cnt = vt[i].rep;
      tick();
      chk($sformatf("vec%0d", i), 32'({OUTPUT, valid, busy, wrap, done}),
          32'({vt[i].out, vt[i].valid, vt[i].busy, vt[i].wrap, vt[i].done}));
    end
    quiet();

    // Two passes: one wrap on the second 0, then done
    nv = 0; nw = 0; nd = 0; wat = -1;
    seq_len = 3'd6; repeat_cnt = 4'd2; start = 1;
    for (int i = 0; i < 20; i++) begin
      tick(); start = 0;
      if (wrap) begin nw++; wat = nv; chk("wrap_code", 32'(OUTPUT), 32'd0); end
      if (valid) nv++;
      if (done) nd++;
    end
    chk("two_pass_valid", 32'(nv), 32'd14);
    chk("two_pass_wraps", 32'(nw), 32'd1);
    chk("two_pass_wrap_pos", 32'(wat), 32'd7);
    chk("two_pass_done", 32'(nd), 32'd1);

    // Infinite repeat: wrap every 7 cycles, never done
    nw = 0; nd = 0;
    repeat_cnt = 4'd0; start = 1;
    for (int i = 0; i < 50; i++) begin
      tick(); start = 0;
      if (wrap) nw++;
      if (done) nd++;
    end
    chk("inf_wraps", 32'(nw), 32'd7);
    chk("inf_no_done", 32'(nd), 32'd0);
    stop = 1; tick(); stop = 0;

    // Step mode: each code held for three cycles
    step_mode = 1; seq_len = 3'd6; repeat_cnt = 4'd1; start = 1;
    tick(); start = 0;
    for (int k = 0; k < 20; k++) begin
      step = (k % 3 == 2);
      tick();
      chk("step_hold", 32'(OUTPUT), 32'(codes[(k + 1) / 3]));
    end
    step = 1; tick(); step = 0;
    chk("step_done", 32'(done), 32'd1);
    tick();

    // One-entry sequence in step mode: wrap per step, code stays 0
    nw = 0;
    seq_len = 3'd0; repeat_cnt = 4'd0; start = 1;
    tick(); start = 0;
    for (int k = 0; k < 9; k++) begin
      step = (k % 3 == 2);
      tick();
      if (wrap) nw++;
      chk("len0_code", 32'(OUTPUT), 32'd0);
    end
    chk("len0_wraps", 32'(nw), 32'd3);
    step = 0; stop = 1; tick(); stop = 0; step_mode = 0;

    // Stop while showing 3
    seq_len = 3'd6; repeat_cnt = 4'd1; start = 1; tick(); start = 0;
    n = 0;
    while (OUTPUT != 3'd3 && n < 20) begin tick(); n++; end
    chk("stop_wait", 32'(OUTPUT), 32'd3);
    stop = 1; tick(); stop = 0;
    chk("stop_idle", 32'({OUTPUT, valid, busy, done}), 32'd0);

    // Start mid-run is ignored; start with stop in idle stays idle
    nv = 0;
    seq_len = 3'd6; repeat_cnt = 4'd1; start = 1; tick(); start = 0; nv++;
    tick(); nv++;
    seq_len = 3'd2; start = 1; tick(); start = 0; nv++;
    for (int i = 0; i < 8; i++) begin tick(); if (valid) nv++; end
    chk("midrun_start_len", 32'(nv), 32'd7);
    tick();
    start = 1; stop = 1; tick(); quiet();
    chk("start_stop_idle", 32'({valid, busy}), 32'd0);

    // Programming
    for (int i = 0; i < 4; i++) begin
      wr_en = 1; wr_addr = IDX_W'(i); wr_data = WIDTH'(7 - i); tick();
    end
    wr_en = 0;
    for (int i = 0; i < 4; i++) e4[i] = PROG ? WIDTH'(7 - i) : WIDTH'(codes[i]);
    start_run(3, 1, 4); drain();
    for (int i = 0; i < 4; i++) chk("prog_play", 32'(got[i]), 32'(e4[i]));
    seq_len = 3'd3; repeat_cnt = 4'd1; start = 1; tick(); start = 0;
    wr_en = 1; wr_addr = '0; wr_data = 3'd1; tick(); wr_en = 0;
    drain();
    start_run(3, 1, 4); drain();
    for (int i = 0; i < 4; i++) chk("busy_write", 32'(got[i]), 32'(e4[i]));
    wr_en = 1; wr_addr = '0; wr_data = 3'd2;
    start_run(3, 1, 1); drain();
    chk("write_with_start", 32'(got[0]), PROG ? 32'd2 : 32'd0);

    // Asynchronous reset mid-pass restores the default table
    start_run(6, 1, 3);
    #2 reset = 0;
    m_reset();
    #1;
    chk("async_reset", 32'({OUTPUT, valid, busy, wrap, done}), 32'd0);
    @(posedge clock); #1 reset = 1;
    start_run(6, 1, 7); drain();
    for (int i = 0; i < 7; i++) chk("post_reset_play", 32'(got[i]), 32'(codes[i]));

    // Random stimulus against the model
    for (int i = 0; i < 400; i++) begin
      start      = ($urandom_range(7) == 0);
      stop       = ($urandom_range(24) == 0);
      if ($urandom_range(15) == 0) step_mode = ~step_mode;
      step       = $urandom_range(1) == 1;
      seq_len    = IDX_W'($urandom_range(7));
      repeat_cnt = REP_W'($urandom_range(3));
      wr_en      = ($urandom_range(5) == 0);
      wr_addr    = IDX_W'($urandom_range(7));
      wr_data    = WIDTH'($urandom_range(7));
      tick();
    end
    quiet(); stop = 1; tick(); quiet(); tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/arb_sequence_controller.md
# arb_sequence_controller

Sequencing controller for the team's arbitrary-sequence counter datapath. It holds a small table of output codes and plays it back in order, with these controls:
- start, stop, free-run and single-step;
- a programmable sequence length;
- a finite or infinite repeat count;
- wrap and done status pulses.

The default table reproduces the standard 0,1,2,3,6,5,7 pattern. Downstream logic consumes `OUTPUT` qualified by `valid`.

## Interface
- `WIDTH`, 3, bit width of each sequence code and of `OUTPUT`
- `DEPTH`, 8, number of table entries (power of two)
- `REP_W`, 4, width of the repeat counter
- `clock`  in  1  single clock, rising edge
- `reset`  in  1  asynchronous, active-low reset
- `start`  in  1  begin playback; honoured only in IDLE
- `stop`  in  1  abort playback; priority over all other controls
- `step_mode`  in  1  1 = advance only on `step`; 0 = advance every cycle
- `step`  in  1  advance strobe, used when `step_mode`=1
- `seq_len`  in  log2(DEPTH)  index of last entry played (sequence is entries 0..seq_len)
- `repeat_cnt`  in  REP_W  number of passes; 0 = infinite
- `wr_en`  in  1  table write strobe (ARBSEQ_PROG_EN only)
- `wr_addr`  in  log2(DEPTH)  table write index
- `wr_data`  in  WIDTH  table write value
- `OUTPUT`  out  WIDTH  current sequence code, registered
- `valid`  out  1  `OUTPUT` is a live sequence value
- `busy`  out  1  controller not in IDLE
- `wrap`  out  1  one-cycle pulse when playback returns from last entry to entry 0
- `done`  out  1  one-cycle pulse after the final pass completes

## Operation
**States:** IDLE, RUN, FINISH.

**Reset** (`reset`=0, asynchronous):
- State goes to IDLE; index to 0.
- `OUTPUT`=0, `valid`=0, `busy`=0, `wrap`=0, `done`=0.
- Table is loaded with the default contents 0,1,2,3,6,5,7,0 (entries 0..7). If DEPTH>8, the remaining entries are 0.

**IDLE:**
- `OUTPUT` holds 0; `valid`=0.
- `start`=1 with `stop`=0:
  - latches `seq_len` into len_q and `repeat_cnt` into passes_q;
  - moves to RUN with index 0.
- `start` together with `stop`: remains in IDLE.

**RUN:**
- `busy`=1, `valid`=1, `OUTPUT`=table[index].
- advance = `step_mode` ? `step` : 1.
- On advance with index<len_q: index increments.
- On advance with index==len_q:
  - if passes_q==0 (infinite) or passes_q>1: index goes to 0, `wrap` pulses, and passes_q decrements unless it is 0;
  - if passes_q==1: go to FINISH.
- `stop`=1 in RUN or FINISH: next cycle is IDLE with `valid`=0 and `OUTPUT`=0. No `done` pulse is generated.
- `start` is ignored while `busy`=1.
- Changes to `seq_len` and `repeat_cnt` after the start pulse have no effect until the next start.

**FINISH:**
- Lasts one cycle: `done`=1, `valid`=0, `busy`=1, `OUTPUT`=0.
- Next state is IDLE.

**seq_len=0:** a one-entry sequence. Every advance is a wrap, or a finish on the last pass.

**Index width:** log2(DEPTH) bits. The index never exceeds len_q.

## Timing
- `start` sampled high in cycle n: `OUTPUT`=table[0] with `valid`=1 in cycle n+1.
- Free-run (`step_mode`=0): one new code per cycle. A pass of L=len_q+1 entries occupies L cycles.
- `wrap` is high in the same cycle that `OUTPUT` shows table[0] of a new pass.
- `done` is high in the cycle after the last code of the last pass; `busy` falls one cycle later.
- Step mode: `step` sampled high in cycle k changes `OUTPUT` in cycle k+1. With no `step`, the value is held indefinitely.
- `stop` sampled high in cycle k: IDLE outputs appear in cycle k+1.
- All outputs are registered; there are no combinational input-to-output paths.

## Configuration
- **ARBSEQ_PROG_EN defined:**
  - `wr_en`/`wr_addr`/`wr_data` write the table on the rising clock edge.
  - Writes are accepted only in IDLE; writes while `busy`=1 are ignored.
  - A write and a `start` in the same cycle: the write completes first, and playback uses the new value.
- **ARBSEQ_PROG_EN undefined:**
  - The table is the constant default contents.
  - The write ports exist but are ignored.

## Test plan
1. **Single pass:** release reset, `seq_len`=6, `repeat_cnt`=1, `step_mode`=0, pulse `start` -> `OUTPUT` = 0,1,2,3,6,5,7 on 7 consecutive cycles with `valid`=1, then a 1-cycle `done`, then `busy`=0.
2. **Two passes:** `repeat_cnt`=2, `seq_len`=6 -> 14 valid codes, with exactly one `wrap`, coincident with the second 0, followed by `done`. Repeat with `repeat_cnt`=0: `wrap` every 7 cycles for 50 cycles and no `done`.
3. **Step mode:** `step_mode`=1, `step` pulsed every 3 cycles -> each code held for 3 cycles, in the same order. `seq_len`=0 -> `OUTPUT` stays 0 and `wrap` pulses on each `step`.
4. **Stop and start:**
   - Assert `stop` while `OUTPUT`=3 -> next cycle `valid`=0, `busy`=0, `OUTPUT`=0, and no `done`.
   - Pulse `start` mid-run -> ignored.
   - Assert `start` and `stop` together in IDLE -> stays IDLE.
5. **Programming (ARBSEQ_PROG_EN):**
   - Write 7,6,5,4 to entries 0..3, then run with `seq_len`=3 -> 7,6,5,4.
   - A write issued while `busy`=1 leaves the table unchanged.
   - Without the macro, the same writes have no effect and playback gives 0,1,2,3.
6. **Reset mid-run:** assert `reset` low asynchronously mid-pass -> all outputs go to 0 immediately. The table returns to its default contents, and a later `start` plays 0,1,2,3,6,5,7.
